// File: rtl/ex2_mem_branch_stage.sv
// EX2 stage: branch resolution with registered redirect, data-memory req/ack access with stall and timeout.
// Optional branch statistics counters are built when EX2_BRANCH_STATS_EN is defined.
module ex2_mem_branch_stage #(
  parameter int DATA_W         = 16,
  parameter int RD_W           = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ex2_alu_result,
  input  logic [DATA_W-1:0] ex2_rs2_data,
  input  logic [DATA_W-1:0] ex2_branch_target,
  input  logic [RD_W-1:0]   ex2_rd,
  input  logic              ex2_zero,
  input  logic              ex2_reg_write,
  input  logic              ex2_mem_read,
  input  logic              ex2_mem_write,
  input  logic              ex2_mem_to_reg,
  input  logic              ex2_branch,
  input  logic              ex2_branch_ne,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              flush,
  output logic [DATA_W-1:0] wb_result,
  output logic [RD_W-1:0]   wb_rd,
  output logic              wb_reg_write,
  output logic              mem_err,
  output logic [15:0]       br_total,
  output logic [15:0]       br_taken
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
  localparam bit         TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  logic [0:0]        state_reg;
  logic [7:0]        cnt_reg;
  logic [DATA_W-1:0] addr_reg, wdata_reg, target_reg;
  logic [RD_W-1:0]   rd_reg;
  logic              we_reg, reg_write_reg, mem_to_reg_reg;
  logic              branch_reg, branch_ne_reg, zero_reg;

  logic              redirect_valid_reg, wb_reg_write_reg, mem_err_reg;
  logic [DATA_W-1:0] redirect_pc_reg, wb_result_reg;
  logic [RD_W-1:0]   wb_rd_reg;

  logic              mem_op, in_wait, timeout_hit, complete, taken;
  logic [DATA_W-1:0] cur_addr, cur_wdata, cur_target;
  logic [RD_W-1:0]   cur_rd;
  logic              cur_we, cur_reg_write, cur_mem_to_reg;
  logic              cur_branch, cur_branch_ne, cur_zero;

  assign mem_op      = ex2_mem_read | ex2_mem_write;
  assign in_wait     = (state_reg == ST_WAIT);
  assign timeout_hit = in_wait && TIMEOUT_EN && (cnt_reg == TIMEOUT_LIMIT);

  // In WAIT the held copies drive everything, so the bus stays stable whatever upstream shows.
  assign cur_addr       = in_wait ? addr_reg        : ex2_alu_result;
  assign cur_wdata      = in_wait ? wdata_reg       : ex2_rs2_data;
  assign cur_target     = in_wait ? target_reg      : ex2_branch_target;
  assign cur_rd         = in_wait ? rd_reg          : ex2_rd;
  assign cur_we         = in_wait ? we_reg          : ex2_mem_write;
  assign cur_reg_write  = in_wait ? reg_write_reg   : ex2_reg_write;
  assign cur_mem_to_reg = in_wait ? mem_to_reg_reg  : ex2_mem_to_reg;
  assign cur_branch     = in_wait ? branch_reg      : ex2_branch;
  assign cur_branch_ne  = in_wait ? branch_ne_reg   : ex2_branch_ne;
  assign cur_zero       = in_wait ? zero_reg        : ex2_zero;

  assign complete = in_wait ? (dmem_ack & ~timeout_hit) : (~mem_op | dmem_ack);
  assign taken    = (cur_branch & cur_zero) | (cur_branch_ne & ~cur_zero);

  // Gated by rst_n so an access in flight is dropped the moment reset asserts.
  assign dmem_req   = rst_n & (in_wait ? ~timeout_hit : mem_op);
  assign stall      = rst_n & (in_wait ? (~dmem_ack & ~timeout_hit) : (mem_op & ~dmem_ack));
  assign dmem_we    = cur_we;
  assign dmem_addr  = cur_addr;
  assign dmem_wdata = cur_wdata;

  assign redirect_valid = redirect_valid_reg;
  assign flush          = redirect_valid_reg;
  assign redirect_pc    = redirect_pc_reg;
  assign wb_result      = wb_result_reg;
  assign wb_rd          = wb_rd_reg;
  assign wb_reg_write   = wb_reg_write_reg;
  assign mem_err        = mem_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg          <= ST_IDLE;
      cnt_reg            <= 8'd0;
      addr_reg           <= '0;
      wdata_reg          <= '0;
      target_reg         <= '0;
      rd_reg             <= '0;
      we_reg             <= 1'b0;
      reg_write_reg      <= 1'b0;
      mem_to_reg_reg     <= 1'b0;
      branch_reg         <= 1'b0;
      branch_ne_reg      <= 1'b0;
      zero_reg           <= 1'b0;
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= '0;
      wb_result_reg      <= '0;
      wb_rd_reg          <= '0;
      wb_reg_write_reg   <= 1'b0;
      mem_err_reg        <= 1'b0;
    end else begin
      redirect_valid_reg <= 1'b0;
      wb_reg_write_reg   <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (mem_op && !dmem_ack) begin
            state_reg      <= ST_WAIT;
            cnt_reg        <= 8'd0;
            addr_reg       <= ex2_alu_result;
            wdata_reg      <= ex2_rs2_data;
            target_reg     <= ex2_branch_target;
            rd_reg         <= ex2_rd;
            we_reg         <= ex2_mem_write;
            reg_write_reg  <= ex2_reg_write;
            mem_to_reg_reg <= ex2_mem_to_reg;
            branch_reg     <= ex2_branch;
            branch_ne_reg  <= ex2_branch_ne;
            zero_reg       <= ex2_zero;
          end
        end
        default: begin
          if (timeout_hit) begin
            mem_err_reg <= 1'b1;
            state_reg   <= ST_IDLE;
          end else if (dmem_ack) begin
            state_reg <= ST_IDLE;
          end else if (cnt_reg != 8'hFF) begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
      endcase

      // An aborted access never reaches here, so it neither writes back nor redirects.
      if (complete) begin
        wb_result_reg    <= cur_mem_to_reg ? dmem_rdata : cur_addr;
        wb_rd_reg        <= cur_rd;
        wb_reg_write_reg <= cur_reg_write;
        if (taken) begin
          redirect_valid_reg <= 1'b1;
          redirect_pc_reg    <= cur_target;
        end
      end
    end
  end

`ifdef EX2_BRANCH_STATS_EN
  logic [15:0] br_total_reg, br_taken_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_total_reg <= 16'd0;
      br_taken_reg <= 16'd0;
    end else if (complete && (cur_branch || cur_branch_ne)) begin
      if (br_total_reg != 16'hFFFF) br_total_reg <= br_total_reg + 16'd1;
      if (taken && br_taken_reg != 16'hFFFF) br_taken_reg <= br_taken_reg + 16'd1;
    end
  end

  assign br_total = br_total_reg;
  assign br_taken = br_taken_reg;
`else
  assign br_total = 16'd0;
  assign br_taken = 16'd0;
`endif

endmodule
